// File: rtl/dsi_pkg.sv
// Shared types and helpers for the DSI command responder: FSM states, long-packet
// data-type nibbles, header ECC and byte-serial CRC-16 (reflected 0x8408).
package dsi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_HDR,
        S_ECC,
        S_PAY,
        S_CRC0,
        S_CRC1,
        S_DONE
    } state_e;

    // Data-type low nibbles that mark a long packet (e.g. 0x29 generic long write, 0x39 DCS long write).
    localparam logic [3:0] DT_LONG_A = 4'h9;
    localparam logic [3:0] DT_LONG_B = 4'hE;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h8408;

    // DSI Hamming ECC over the 24-bit header {WC_hi, WC_lo, DI}.
    function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
               d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
               d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
               d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
               d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    // One byte of the reflected CRC-16 (LSB first through the shift register).
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Byte-serial CRC-16 engine for the long-packet payload checksum.
// Only compiled into the build when DSI_CRC_EN is defined.
`ifdef DSI_CRC_EN
module dsi_crc16
    import dsi_pkg::*;
(
    input  logic        clkin,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            crc_q <= CRC_INIT;
        end else if (clr) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc16_byte(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule
`endif

// File: rtl/dsi_cmd_responder.sv
// DSI TX command responder: acks the assembler, streams header/ECC/payload/CRC from a
// FWFT byte FIFO to the PHY. Build option DSI_CRC_EN enables the payload CRC engine.
module dsi_cmd_responder
    import dsi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       cmd_rq,
    input  logic       hs_mode,
    output logic       cmd_ack,
    output logic       tx_act,
    output logic       time_out,
    input  logic       empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic [7:0] phy_data,
    output logic       phy_valid,
    input  logic       phy_ready,
    output logic       phy_hs
);

    localparam int unsigned SW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYC - 1);

    state_e        state_q;
    logic          cmd_ack_q;
    logic          tx_act_q;
    logic          time_out_q;
    logic          phy_valid_q;
    logic          phy_hs_q;
    logic [7:0]    phy_data_q;
    logic [23:0]   hdr_q;
    logic [1:0]    hcnt_q;
    logic [15:0]   wc_q;
    logic [SW-1:0] stall_q;
    logic [SW-1:0] stall_d;

    logic          in_fetch;
    logic          out_free;
    logic          xfer;
    logic          pop;
    logic          stall_inc;
    logic          stall_hit;
    logic          is_long;
    logic [15:0]   crc_val;

    always_comb begin
        // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
        stall_inc = 1'b0;
        in_fetch  = (state_q == S_HDR) || (state_q == S_PAY);
        out_free  = !phy_valid_q || phy_ready;
        xfer      = phy_valid_q && phy_ready;
        pop       = in_fetch && !empty && out_free;
        if (state_q == S_IDLE) begin
            stall_inc = cmd_rq && empty;
        end else begin
            stall_inc = !xfer && ((in_fetch && empty) || (phy_valid_q && !phy_ready));
        end
        stall_hit = stall_inc && (stall_q == STALL_LAST);
        stall_d   = stall_inc ? stall_q + 1'b1 : '0;
        is_long   = (hdr_q[3:0] == DT_LONG_A) || (hdr_q[3:0] == DT_LONG_B);
    end

`ifdef DSI_CRC_EN
    logic [15:0] crc_w;

    dsi_crc16 u_crc (
        .clkin (clkin),
        .rstn  (rstn),
        .clr   (state_q == S_ACK),
        .en    (pop && (state_q == S_PAY)),
        .din   (fifo_dout),
        .crc   (crc_w)
    );

    assign crc_val = crc_w;
`else
    assign crc_val = 16'h0000;
`endif

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cmd_ack_q   <= 1'b0;
            tx_act_q    <= 1'b0;
            time_out_q  <= 1'b0;
            phy_valid_q <= 1'b0;
            phy_hs_q    <= 1'b0;
            phy_data_q  <= 8'h00;
            hdr_q       <= 24'h000000;
            hcnt_q      <= 2'd0;
            wc_q        <= 16'h0000;
            stall_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values regardless of order.
            cmd_ack_q  <= 1'b0;
            time_out_q <= 1'b0;
            stall_q    <= stall_d;
            if (xfer) begin
                phy_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_rq && !empty) begin
                        cmd_ack_q <= 1'b1;
                        phy_hs_q  <= hs_mode;
                        state_q   <= S_ACK;
                    end
                end
                S_ACK: begin
                    tx_act_q <= 1'b1;
                    hcnt_q   <= 2'd0;
                    state_q  <= S_HDR;
                end
                S_HDR: begin
                    if (pop) begin
                        phy_data_q  <= fifo_dout;
                        phy_valid_q <= 1'b1;
                        hdr_q       <= {fifo_dout, hdr_q[23:8]};
                        hcnt_q      <= hcnt_q + 2'd1;
                        if (hcnt_q == 2'd2) begin
                            state_q <= S_ECC;
                        end
                    end
                end
                S_ECC: begin
                    if (out_free) begin
                        phy_data_q  <= {2'b00, dsi_ecc(hdr_q)};
                        phy_valid_q <= 1'b1;
                        wc_q        <= hdr_q[23:8];
                        if (!is_long) begin
                            state_q <= S_DONE;
                        end else if (hdr_q[23:8] != 16'h0000) begin
                            state_q <= S_PAY;
                        end else begin
                            state_q <= S_CRC0;
                        end
                    end
                end
                S_PAY: begin
                    if (pop) begin
                        phy_data_q  <= fifo_dout;
                        phy_valid_q <= 1'b1;
                        wc_q        <= wc_q - 16'd1;
                        if (wc_q == 16'd1) begin
                            state_q <= S_CRC0;
                        end
                    end
                end
                S_CRC0: begin
                    if (out_free) begin
                        phy_data_q  <= crc_val[7:0];
                        phy_valid_q <= 1'b1;
                        state_q     <= S_CRC1;
                    end
                end
                S_CRC1: begin
                    if (out_free) begin
                        phy_data_q  <= crc_val[15:8];
                        phy_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Wait for the final byte to be taken before closing the frame.
                    if (out_free) begin
                        tx_act_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Stall limit: pulse time_out; mid-packet it also abandons the packet.
            if (stall_hit) begin
                time_out_q <= 1'b1;
                stall_q    <= '0;
                if (state_q != S_IDLE) begin
                    phy_valid_q <= 1'b0;
                    tx_act_q    <= 1'b0;
                    state_q     <= S_IDLE;
                end
            end
        end
    end

    assign cmd_ack    = cmd_ack_q;
    assign tx_act     = tx_act_q;
    assign time_out   = time_out_q;
    assign fifo_rd_en = pop;
    assign phy_data   = phy_data_q;
    assign phy_valid  = phy_valid_q;
    assign phy_hs     = phy_hs_q;

endmodule

// File: tb/tb_dsi_cmd_responder.sv
// Directed bench for dsi_cmd_responder: FWFT FIFO model, PHY sink with optional
// back-pressure, and hand-computed byte streams (ECC/CRC values worked out by hand).
module tb_dsi_cmd_responder;

    localparam int TO = 16;

    logic       clkin = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_rq = 1'b0;
    logic       hs_mode = 1'b0;
    logic       cmd_ack;
    logic       tx_act;
    logic       time_out;
    logic       empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic [7:0] phy_data;
    logic       phy_valid;
    logic       phy_ready = 1'b1;
    logic       phy_hs;

    always #5 clkin = ~clkin;

    // FWFT FIFO model: bench writes at wr_ptr, DUT pops at rd_ptr.
    logic [7:0] mem [0:255];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    int         underflow = 0;

    assign empty     = (rd_ptr == wr_ptr);
    assign fifo_dout = mem[rd_ptr];

    always @(posedge clkin) begin
        if (fifo_rd_en) begin
            if (empty) underflow++;
            else rd_ptr <= rd_ptr + 8'd1;
        end
    end

    dsi_cmd_responder #(.TIMEOUT_CYC(TO)) dut (
        .clkin      (clkin),
        .rstn       (rstn),
        .cmd_rq     (cmd_rq),
        .hs_mode    (hs_mode),
        .cmd_ack    (cmd_ack),
        .tx_act     (tx_act),
        .time_out   (time_out),
        .empty      (empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .phy_data   (phy_data),
        .phy_valid  (phy_valid),
        .phy_ready  (phy_ready),
        .phy_hs     (phy_hs)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] cap_q[$];
    int         cap_c[$];
    logic [7:0] exp_q[$];
    int         last_hs = 0, tx_fall = 0, fall_cnt = 0, rise_cyc = 0;
    int         ack_cnt = 0, ack_cyc = 0, to_cnt = 0, to_cyc = 0;
    int         hold_err = 0, low_cnt = 0, bp_left = 0;
    bit         tx_prev = 1'b0, prev_stall = 1'b0, bp_arm = 1'b0;
    logic [7:0] prev_data = 8'h00, bp_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clkin);
        if (phy_valid && phy_ready) begin
            cap_q.push_back(phy_data);
            cap_c.push_back(cyc);
            last_hs = cyc;
        end
        if (prev_stall && (phy_data !== prev_data)) hold_err++;
        prev_stall = phy_valid && !phy_ready;
        prev_data  = phy_data;
        if (phy_valid && !phy_ready) low_cnt++;
        if (tx_prev && !tx_act) begin tx_fall = cyc; fall_cnt++; end
        if (!tx_prev && tx_act) rise_cyc = cyc;
        tx_prev = tx_act;
        if (cmd_ack) begin ack_cnt++; ack_cyc = cyc; end
        if (time_out) begin to_cnt++; to_cyc = cyc; end
        cyc++;
        @(posedge clkin);
        #1;
        if (bp_left > 0) begin
            bp_left--;
            if (bp_left == 0) phy_ready = 1'b1;
        end else if (bp_arm && phy_valid && (phy_data == bp_byte)) begin
            phy_ready = 1'b0;
            bp_left   = 5;
            bp_arm    = 1'b0;
        end
    endtask

    task automatic check_bytes(input int base);
        check("byte_count", cap_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < cap_q.size()) check($sformatf("byte%0d", i), cap_q[base + i], exp_q[i]);
        end
    endtask

    task automatic wait_ack(input int a0);
        int n = 0;
        while (ack_cnt == a0 && n < 60) begin tick(); n++; end
        cmd_rq = 1'b0;
        check("ack_seen", ack_cnt - a0, 1);
    endtask

    // Request one packet, collect its bytes, compare against exp_q.
    task automatic send(input logic hs, input bit timing);
        int base, a0, f0, n;
        base = cap_q.size();
        a0 = ack_cnt;
        f0 = fall_cnt;
        hs_mode = hs;
        cmd_rq = 1'b1;
        wait_ack(a0);
        check("phy_hs", phy_hs, hs);
        n = 0;
        while (fall_cnt == f0 && n < 200) begin tick(); n++; end
        check("tx_act_fall", fall_cnt - f0, 1);
        tick();
        tick();
        check("ack_once", ack_cnt - a0, 1);
        check_bytes(base);
        if (timing && cap_q.size() > base) begin
            check("tx_act_rise", rise_cyc - ack_cyc, 1);
            check("burst_len", cap_c[cap_q.size() - 1] - cap_c[base], exp_q.size() - 1);
            check("tx_act_lat", tx_fall - last_hs, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, a0, t0, t1, p1;

        // Reset state
        repeat (3) @(posedge clkin);
        #1;
        check("rst_outputs", {cmd_ack, tx_act, time_out, fifo_rd_en, phy_valid, phy_hs, phy_data}, 0);
        rstn = 1'b1;
        repeat (2) tick();

        // Short packet, HS
        push(8'h05); push(8'h29); push(8'h00);
        exp_q = '{8'h05, 8'h29, 8'h00, 8'h1C};
        send(1'b1, 1'b1);

        // Short packet, LP
        push(8'h05); push(8'h11); push(8'h00);
        exp_q = '{8'h05, 8'h11, 8'h00, 8'h36};
        send(1'b0, 1'b1);

        // Long packet, WC=9, payload "123456789"
        push(8'h29); push(8'h09); push(8'h00);
        for (int i = 0; i < 9; i++) push(8'h31 + 8'(i));
`ifdef DSI_CRC_EN
        exp_q = '{8'h29, 8'h09, 8'h00, 8'h23, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                  8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
`else
        exp_q = '{8'h29, 8'h09, 8'h00, 8'h23, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                  8'h36, 8'h37, 8'h38, 8'h39, 8'h00, 8'h00};
`endif
        send(1'b1, 1'b1);

        // Back-pressure: PHY holds off byte 0x29 for 5 cycles
        push(8'h05); push(8'h29); push(8'h00);
        exp_q = '{8'h05, 8'h29, 8'h00, 8'h1C};
        low_cnt  = 0;
        hold_err = 0;
        bp_byte  = 8'h29;
        bp_arm   = 1'b1;
        send(1'b1, 1'b0);
        check("bp_low_cycles", low_cnt, 5);
        check("bp_hold", hold_err, 0);

        // Abort: long header only, FIFO then runs dry
        push(8'h29); push(8'h09); push(8'h00);
        exp_q = '{8'h29, 8'h09, 8'h00, 8'h23};
        base = cap_q.size();
        a0 = ack_cnt;
        t0 = to_cnt;
        cmd_rq = 1'b1;
        wait_ack(a0);
        n = 0;
        while (to_cnt == t0 && n < 100) begin tick(); n++; end
        check("abort_pulse", to_cnt - t0, 1);
        check("abort_latency", to_cyc - last_hs, TO + 1);
        check("abort_pulse_width", time_out, 0);
        check("abort_tx_act", tx_act, 0);
        check("abort_valid", phy_valid, 0);
        check_bytes(base);
        repeat (20) tick();
        check("abort_single", to_cnt - t0, 1);
        check("abort_no_reack", ack_cnt - a0, 1);

        // IDLE wait: request with empty FIFO times out periodically and stays pending
        a0 = ack_cnt;
        t0 = to_cnt;
        cmd_rq = 1'b1;
        n = 0;
        while (to_cnt == t0 && n < 60) begin tick(); n++; end
        t1 = to_cnt;
        p1 = to_cyc;
        n = 0;
        while (to_cnt == t1 && n < 60) begin tick(); n++; end
        check("idle_to_seen", to_cnt - t0, 2);
        check("idle_to_period", to_cyc - p1, TO);
        check("idle_no_ack", ack_cnt - a0, 0);
        push(8'h05); push(8'h29); push(8'h00);
        exp_q = '{8'h05, 8'h29, 8'h00, 8'h1C};
        send(1'b0, 1'b1);

        // Asynchronous reset during payload
        push(8'h29); push(8'h09); push(8'h00);
        for (int i = 0; i < 9; i++) push(8'h31 + 8'(i));
        a0 = ack_cnt;
        hs_mode = 1'b1;
        cmd_rq = 1'b1;
        wait_ack(a0);
        n = 0;
        while (!(phy_valid && phy_data == 8'h33) && n < 50) begin tick(); n++; end
        check("rst_reached_pay", phy_data, 8'h33);
        check("rst_tx_act_before", tx_act, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_outputs", {cmd_ack, tx_act, time_out, fifo_rd_en, phy_valid, phy_hs, phy_data}, 0);
        @(posedge clkin);
        #1;
        rstn = 1'b1;
        tick();
        wr_ptr = rd_ptr;
        push(8'h05); push(8'h11); push(8'h00);
        exp_q = '{8'h05, 8'h11, 8'h00, 8'h36};
        send(1'b1, 1'b1);

        check("fifo_underflow", underflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsi_cmd_responder.md
# dsi_cmd_responder

Command-side responder of the MIPI DSI TX path. It accepts a level `cmd_rq` from the packet assembler and acknowledges it with a one-cycle `cmd_ack`. It then pops one DSI packet from a first-word-fall-through byte FIFO, appends the header ECC and the long-packet checksum, and streams the bytes to the lane/PHY byte interface. `tx_act` frames the transmission; its falling edge is the assembler's completion event.

## Interface
- `TIMEOUT_CYC`, default 1024: stall-cycle limit before abort/`time_out`
- `clkin`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `cmd_rq`  in  1  level request from assembler
- `hs_mode`  in  1  HS(1)/LP(0) select, sampled at ack
- `cmd_ack`  out  1  one-cycle acknowledge
- `tx_act`  out  1  packet in progress
- `time_out`  out  1  one-cycle stall/abort pulse
- `empty`  in  1  FIFO empty
- `fifo_dout`  in  8  FWFT head byte, valid when `!empty`
- `fifo_rd_en`  out  1  pop head byte
- `phy_data`  out  8  byte to PHY
- `phy_valid`  out  1  byte valid
- `phy_ready`  in  1  PHY accepts byte
- `phy_hs`  out  1  latched `hs_mode` for current packet

## Operation
- Reset value of every output is 0. `rstn` low mid-packet drops all outputs immediately. The FIFO is not drained.
- States: IDLE, ACK, HDR, ECC, PAY, CRC0, CRC1, DONE.
- IDLE → ACK when `cmd_rq && !empty`. ACK asserts `cmd_ack` for exactly 1 cycle and latches `hs_mode` into `phy_hs`.
- HDR pops 3 bytes in order: DI, WC_lo, WC_hi. Each byte is forwarded as read. The 24-bit header is accumulated for the ECC.
- ECC emits `{2'b00, ecc6}`, using the DSI Hamming ECC over `{WC_hi, WC_lo, DI}`.
- The packet is long iff `DI[3:0]` is `4'h9` or `4'hE`. Otherwise it is short and ECC → DONE.
- For a long packet:
  - ECC → PAY if WC≠0; otherwise ECC → CRC0.
  - PAY forwards WC bytes using a 16-bit down-counter. The last byte goes to CRC0.
  - CRC0/CRC1 emit the checksum, LSB first.
- CRC: CRC-16, poly x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, no final XOR, computed over payload bytes only.
- DONE deasserts `tx_act` and returns to IDLE. A new request may be acked the following cycle.
- `fifo_rd_en` fires only when the output register is free or being emptied (`!phy_valid || phy_ready`) and `!empty`.
- Stall: a cycle in HDR or PAY with `empty`, or any cycle with `phy_valid && !phy_ready`, increments the stall counter. Any transfer clears it.
- Abort: when the stall count reaches `TIMEOUT_CYC`:
  - `time_out` pulses for 1 cycle.
  - `phy_valid` and `tx_act` drop.
  - FSM → IDLE. Remaining packet bytes stay in the FIFO.
- IDLE wait: `cmd_rq && empty` for `TIMEOUT_CYC` cycles pulses `time_out` and restarts the count. The request stays pending.
- `cmd_rq` low at ACK is ignored, because the ack has already been committed.

## Timing
- Request to ack: `cmd_rq` sampled high in IDLE gives `cmd_ack` high on the next cycle.
- `tx_act`: rises the cycle after `cmd_ack` and falls one cycle after the last byte handshake (`phy_valid && phy_ready`).
- Output register: `phy_data` and `phy_valid` are registered, giving 1-cycle latency from pop to valid.
- Throughput: 1 byte/cycle with `phy_ready` held high.
- Back-pressure: `phy_data` is held stable while `phy_valid && !phy_ready`.
- ECC: presented the cycle after WC_hi is accepted into the output register, with no bubble.
- Burst lengths:
  - Short packet: 4 consecutive bytes.
  - Long packet: 6+WC bytes.

## Configuration
- `DSI_CRC_EN` defined: CRC is computed as specified.
- `DSI_CRC_EN` undefined: the CRC engine is removed and CRC0/CRC1 emit 0x00, 0x00. State sequence and timing are unchanged.

## Structure
- Package `dsi_pkg` holds:
  - state enum;
  - long-packet DT nibble constants;
  - `dsi_ecc(input [23:0])` function;
  - `crc16_byte(crc, byte)` function.
- One sub-module, `dsi_crc16`: byte-serial CRC with `clr`/`en`/`din`/`crc` ports. It is instanced only under `DSI_CRC_EN`.

## Test plan
- Short packet: FIFO holds 05 29 00, `phy_ready`=1, `hs_mode`=1.
  - `cmd_ack` 1 cycle, `phy_hs`=1.
  - PHY bytes 05 29 00 1C on 4 consecutive cycles.
  - `tx_act` falls 1 cycle after the last byte.
- Short packet: FIFO holds 05 11 00 → bytes 05 11 00 36.
- Long packet, `DSI_CRC_EN` defined: 29 09 00 followed by ASCII "123456789".
  - Bytes: header, ECC (matches reference model), 9 payload bytes, then 91 6F.
  - Same packet without the macro: tail is 00 00.
- Back-pressure: short packet with `phy_ready` low for 5 cycles on byte 2 → `phy_data` holds 29 throughout, no byte lost or duplicated.
- Abort: `TIMEOUT_CYC`=16; FIFO supplies 3 header bytes of a long packet, then goes empty.
  - `time_out` pulses after 16 stall cycles.
  - `tx_act` drops and FSM returns to IDLE.
- Reset: `rstn` low during PAY → all outputs 0 asynchronously. After release, a new short packet is acked and sent correctly.
